result_uart_tx: RTL

Serial result-reporting stage downstream of the LFSR search modules. It accepts completed tap-vector result words on a valid/ready handshake and buffers them in a small FIFO. Each word is transmitted as a framed byte sequence over an 8N1 UART line on `tx`, which drives the board TX pin. It lets a burst of simultaneous "found" events from parallel search modules be reported without loss, up to the FIFO depth.

---
 rtl/result_uart_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/result_uart_tx.sv
// Buffers result words in a small FIFO and sends each one as an 8N1 UART frame: SYNC_BYTE, then data bytes MSB first.
// Latency: a push into an empty FIFO is popped 1 edge later, and tx falls 2 edges after the push; one frame is (BYTES+1)*10*CLKS_PER_BIT cycles.
// Backpressure: in_ready drops while the FIFO is full; a word offered while full is dropped and sets sticky overflow.
module result_uart_tx #(
  parameter int          WORD_W       = 48,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              overflow
);

  localparam int BYTES  = WORD_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(BYTES + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                push;
  logic                pop;

  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [IDX_W-1:0]    byte_idx;
  logic [7:0]          cur_byte;
  logic [WORD_W-1:0]   shreg;

  // The FIFO is only drained by the FSM while it sits in IDLE, so a pop always starts a new frame.
  assign in_ready = (count != CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign busy     = (state != IDLE) || (count != '0);

  // Storage array: written on accepted pushes only; needs no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers and occupancy count; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

  // Frame sequencer. tx is registered from the current state, so the line lags the state by one cycle
  // but every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      cur_byte <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (count != '0) begin
            shreg    <= mem[rd_ptr];
            cur_byte <= SYNC_BYTE;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= cur_byte[bit_idx];
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (byte_idx < IDX_LAST) begin
              // Next data byte follows the stop bit with no idle gap.
              cur_byte <= shreg[WORD_W-1 -: 8];
              shreg    <= shreg << 8;
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
